// File: rtl/lot_controller.sv
// Parking-lot occupancy counter with a saturating count and sticky error flag,
// plus the entry-gate sequencer (IDLE -> OPEN -> SETTLE).
module lot_controller #(
    parameter int unsigned CAPACITY      = 16,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned OPEN_CYCLES   = 100,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             req_i,
    output logic             gate_open_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             denied_o,
    output logic             timeout_o,
    output logic             error_o
);

    localparam int unsigned OTW = $clog2(OPEN_CYCLES + 1);
    localparam int unsigned STW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        OPEN   = 3'b010,
        SETTLE = 3'b100
    } state_e;

    state_e           state_q;
    logic [OTW-1:0]   open_tmr_q;
    logic [STW-1:0]   settle_tmr_q;
    logic             gate_open_q;
    logic             denied_q;
    logic             timeout_q;
    logic             deny_armed_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    assign full_o      = (count_q == CNT_W'(CAPACITY));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign error_o     = error_q;
    assign gate_open_o = gate_open_q;
    assign denied_o    = denied_q;
    assign timeout_o   = timeout_q;

    always_comb begin
        count_d = count_q;
        error_d = error_q;
        if (inc_i && !dec_i) begin
            if (full_o) error_d = 1'b1;
            else        count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (empty_o) error_d = 1'b1;
            else         count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            open_tmr_q   <= '0;
            settle_tmr_q <= '0;
            gate_open_q  <= 1'b0;
            denied_q     <= 1'b0;
            timeout_q    <= 1'b0;
            deny_armed_q <= 1'b1;
        end else begin
            denied_q  <= 1'b0;
            timeout_q <= 1'b0;
            // A refusal re-arms only once the waiting car has gone away.
            if (!req_i) deny_armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (req_i && !full_o) begin
                        state_q     <= OPEN;
                        open_tmr_q  <= '0;
                        gate_open_q <= 1'b1;
                    end else if (req_i && full_o && deny_armed_q) begin
                        denied_q     <= 1'b1;
                        deny_armed_q <= 1'b0;
                    end
                end
                OPEN: begin
                    if (inc_i) begin
                        state_q      <= SETTLE;
                        settle_tmr_q <= '0;
                        gate_open_q  <= 1'b0;
                    end else if (open_tmr_q == OTW'(OPEN_CYCLES - 1)) begin
                        state_q      <= SETTLE;
                        settle_tmr_q <= '0;
                        gate_open_q  <= 1'b0;
                        timeout_q    <= 1'b1;
                    end else begin
                        open_tmr_q <= open_tmr_q + OTW'(1);
                    end
                end
                SETTLE: begin
                    if (settle_tmr_q == STW'(SETTLE_CYCLES - 1)) state_q <= IDLE;
                    else settle_tmr_q <= settle_tmr_q + STW'(1);
                end
                default: begin
                    state_q     <= IDLE;
                    gate_open_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lot_controller.sv
// Directed + random bench for lot_controller; expectations come from a
// cycle-stamped behavioural model of the lot and gate.
module tb_lot_controller;

    localparam int CAP    = 3;
    localparam int OPENC  = 8;
    localparam int SETTLE = 2;
    localparam int CW     = 8;

    logic          clk;
    logic          reset, inc, dec, req;
    logic          gate_open_o, full_o, empty_o, denied_o, timeout_o, error_o;
    logic [CW-1:0] count_o;

    lot_controller #(
        .CAPACITY(CAP),
        .CNT_W(CW),
        .OPEN_CYCLES(OPENC),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .inc_i(inc),
        .dec_i(dec),
        .req_i(req),
        .gate_open_o(gate_open_o),
        .count_o(count_o),
        .full_o(full_o),
        .empty_o(empty_o),
        .denied_o(denied_o),
        .timeout_o(timeout_o),
        .error_o(error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: the gate is described by the edge it opened at and the first
    // edge at which a waiting car may be served again.
    int m_count = 0;
    bit m_err = 0, m_gate = 0, m_den = 0, m_to = 0, m_armed = 1;
    int m_opened = 0, m_accept = 0;

    int den_p, to_p, opn;
    logic r, i, d, q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit rr, input bit ii, input bit dd, input bit qq);
        int old;
        old = m_count;
        if (rr) begin
            m_count = 0; m_err = 0; m_gate = 0; m_den = 0; m_to = 0;
            m_armed = 1; m_accept = cyc + 1;
        end else begin
            m_den = 0; m_to = 0;
            if (ii && !dd) begin
                if (old == CAP) m_err = 1; else m_count = old + 1;
            end else if (dd && !ii) begin
                if (old == 0) m_err = 1; else m_count = old - 1;
            end
            if (m_gate) begin
                if (ii) begin
                    m_gate = 0; m_accept = cyc + SETTLE + 1;
                end else if (cyc - m_opened == OPENC) begin
                    m_gate = 0; m_to = 1; m_accept = cyc + SETTLE + 1;
                end
            end else if (qq && cyc >= m_accept) begin
                if (old < CAP) begin
                    m_gate = 1; m_opened = cyc;
                end else if (m_armed) begin
                    m_den = 1; m_armed = 0;
                end
            end
            if (!qq) m_armed = 1;
        end
    endtask

    task automatic tick(input logic rr, input logic ii, input logic dd, input logic qq);
        reset = rr; inc = ii; dec = dd; req = qq;
        @(posedge clk);
        cyc++;
        model_edge(rr, ii, dd, qq);
        #1;
        chk("gate_open", {31'd0, gate_open_o}, {31'd0, m_gate});
        chk("count", {24'd0, count_o}, m_count);
        chk("full", {31'd0, full_o}, (m_count == CAP) ? 1 : 0);
        chk("empty", {31'd0, empty_o}, (m_count == 0) ? 1 : 0);
        chk("denied", {31'd0, denied_o}, {31'd0, m_den});
        chk("timeout", {31'd0, timeout_o}, {31'd0, m_to});
        chk("error", {31'd0, error_o}, {31'd0, m_err});
    endtask

    initial begin
        reset = 1'b1; inc = 1'b0; dec = 1'b0; req = 1'b0;

        // Reset with req/inc active, then release.
        repeat (2) begin
            tick(1, 1, 0, 1);
            chk("rst_gate", {31'd0, gate_open_o}, 0);
            chk("rst_count", {24'd0, count_o}, 0);
            chk("rst_empty", {31'd0, empty_o}, 1);
            chk("rst_error", {31'd0, error_o}, 0);
        end
        tick(0, 0, 0, 0);
        chk("rel_gate", {31'd0, gate_open_o}, 0);
        chk("rel_count", {24'd0, count_o}, 0);
        chk("rel_empty", {31'd0, empty_o}, 1);

        // Normal entry, settle, reopen.
        tick(0, 0, 0, 1);
        chk("entry_open", {31'd0, gate_open_o}, 1);
        repeat (3) tick(0, 0, 0, 0);
        chk("entry_still_open", {31'd0, gate_open_o}, 1);
        tick(0, 1, 0, 0);
        chk("entry_closed", {31'd0, gate_open_o}, 0);
        chk("entry_count", {24'd0, count_o}, 1);
        tick(0, 0, 0, 1);
        chk("settle_hold1", {31'd0, gate_open_o}, 0);
        tick(0, 0, 0, 1);
        chk("settle_hold2", {31'd0, gate_open_o}, 0);
        tick(0, 0, 0, 1);
        chk("reopen", {31'd0, gate_open_o}, 1);

        // Timeout with no entry.
        opn = 1; to_p = 0;
        repeat (10) begin
            tick(0, 0, 0, 0);
            opn  += int'(gate_open_o);
            to_p += int'(timeout_o);
        end
        chk("timeout_open_cycles", opn, OPENC);
        chk("timeout_pulses", to_p, 1);
        chk("timeout_count", {24'd0, count_o}, 1);

        // Full lot: one refusal per waiting episode.
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        chk("fill_full", {31'd0, full_o}, 1);
        den_p = 0; opn = 0;
        repeat (10) begin
            tick(0, 0, 0, 1);
            den_p += int'(denied_o);
            opn   += int'(gate_open_o);
        end
        chk("full_denied_once", den_p, 1);
        chk("full_gate_closed", opn, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("denied_again", {31'd0, denied_o}, 1);
        tick(0, 0, 0, 1);
        chk("denied_one_cycle", {31'd0, denied_o}, 0);

        // Simultaneous and saturating pulses.
        tick(0, 0, 1, 0);
        tick(0, 1, 1, 0);
        chk("both_count", {24'd0, count_o}, 2);
        chk("both_error", {31'd0, error_o}, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("underflow_count", {24'd0, count_o}, 0);
        chk("underflow_error", {31'd0, error_o}, 1);
        repeat (4) tick(0, 0, 0, 0);
        chk("error_sticky", {31'd0, error_o}, 1);
        tick(1, 0, 0, 0);
        chk("error_cleared", {31'd0, error_o}, 0);
        repeat (3) tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        chk("overflow_count", {24'd0, count_o}, 3);
        chk("overflow_error", {31'd0, error_o}, 1);
        tick(1, 0, 0, 0);

        // Reset while the gate is open.
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 1);
        chk("mid_open", {31'd0, gate_open_o}, 1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("mid_rst_gate", {31'd0, gate_open_o}, 0);
        chk("mid_rst_count", {24'd0, count_o}, 0);
        to_p = int'(timeout_o);
        repeat (10) begin
            tick(0, 0, 0, 0);
            to_p += int'(timeout_o);
        end
        chk("mid_rst_no_timeout", to_p, 0);
        tick(0, 0, 0, 1);
        chk("mid_rst_reopen", {31'd0, gate_open_o}, 1);
        tick(0, 1, 0, 0);

        // Random traffic against the model.
        repeat (600) begin
            r = ($urandom_range(0, 63) == 0);
            i = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 4) == 0);
            q = ($urandom_range(0, 1) == 0);
            tick(r, i, d, q);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lot_controller.md
# lot_controller

Occupancy counter and entry-gate sequencer for the parking lot. Consumes the one-cycle `inc`/`dec` pulses from the lane car detector and tracks cars present, bounded by `CAPACITY`. Drives the entry barrier through an open/settle state machine: opens on a waiting car only if a space is free, closes on entry or timeout. Sits between the detector and the barrier/display drivers.

## Interface

Parameters:
- `CAPACITY`, 16: number of spaces; must be ≥ 1.
- `CNT_W`, 8: width of `count`; must satisfy 2^CNT_W > CAPACITY.
- `OPEN_CYCLES`, 100: cycles the gate stays open waiting for an entry; must be ≥ 1.
- `SETTLE_CYCLES`, 4: cycles the gate is held closed after it closes, before a new request is accepted; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inc`  in  1  one-cycle pulse: a car completed entry.
- `dec`  in  1  one-cycle pulse: a car completed exit.
- `req`  in  1  level: a car is waiting at the entry gate.
- `gate_open`  out  1  level: barrier raised.
- `count`  out  CNT_W  cars currently in the lot.
- `full`  out  1  `count == CAPACITY`.
- `empty`  out  1  `count == 0`.
- `denied`  out  1  one-cycle pulse: a request was refused because the lot is full.
- `timeout`  out  1  one-cycle pulse: the gate closed without an entry.
- `error`  out  1  sticky: an overflow or underflow was attempted.

## Operation

- Reset values: `count` = 0, `empty` = 1, `full` = 0, `gate_open` = 0, `denied` = 0, `timeout` = 0, `error` = 0. State is IDLE and all internal timers are 0.
- Counter update, applied each cycle:
  - `inc` only: `count` + 1.
  - `dec` only: `count` − 1.
  - Both or neither: `count` unchanged.
- Counter saturation:
  - `inc` only while `count == CAPACITY`: `count` holds and `error` sets.
  - `dec` only while `count == 0`: `count` holds and `error` sets.
  - `error` clears only on `reset`.
- `full` and `empty` decode directly from the `count` register, so they change in the same cycle as `count`.
- State machine (one-hot; `gate_open` = 1 only in OPEN):
  - IDLE:
    - `req && !full` → OPEN, and the open timer loads 0.
    - `req && full` → stay in IDLE and pulse `denied` once. No further `denied` until `req` has been seen at 0 for at least one cycle.
  - OPEN:
    - `inc` → SETTLE.
    - Otherwise, when the open timer reaches `OPEN_CYCLES` − 1 → SETTLE and pulse `timeout`.
    - `inc` has priority over the timeout expiring in the same cycle: no `timeout` pulse.
    - `req` is ignored.
  - SETTLE: hold for `SETTLE_CYCLES` cycles → IDLE. `req` is ignored.
- `dec` is accepted in every state and never affects the state machine.
- An `inc` outside OPEN still updates the counter, which covers detector reversals and manual entry.

## Timing

- All outputs are registered.
- Latencies:
  - `req` sampled high at edge N in IDLE with space free → `gate_open` = 1 from edge N+1.
  - `inc` sampled at edge N in OPEN → `count` updated and `gate_open` = 0 from edge N+1.
  - Gate entered OPEN at edge N with no `inc` → `gate_open` = 0 and `timeout` = 1 from edge N + `OPEN_CYCLES`; `timeout` lasts one cycle.
  - SETTLE entered at edge M → IDLE from edge M + `SETTLE_CYCLES`; the earliest reopen is edge M + `SETTLE_CYCLES` + 1.
  - `denied` asserts the cycle after the qualifying `req` sample and lasts one cycle.
- Full while OPEN: the gate stays open until `inc` or timeout. The final free space was checked on entry to OPEN.
- `reset` asserted in any state: all outputs take their reset values at the next edge, and the gate drops immediately.

## Test plan

Use `CAPACITY`=3, `OPEN_CYCLES`=8, `SETTLE_CYCLES`=2.

- **Reset:** `reset` for 2 cycles with `req`/`inc` high → `gate_open` = 0, `count` = 0, `empty` = 1, `error` = 0 for both cycles and the cycle after release.
- **Normal entry:** `req` = 1 at edge 10; `inc` pulse at edge 14 → `gate_open` = 1 for edges 11–14, 0 from edge 15; `count` = 1 at edge 15; no reopen before edge 17.
- **Timeout:** `req` = 1, no `inc` → `gate_open` = 1 for 8 cycles; `timeout` pulses once as it drops; `count` unchanged.
- **Full lot:** fill to `count` = 3, then hold `req` high for 10 cycles → `full` = 1, `gate_open` stays 0, exactly one `denied` pulse. Then drop `req` for 1 cycle and raise it again → a second `denied` pulse.
- **Simultaneous and saturating pulses:**
  - At `count` = 2, `inc` and `dec` in the same cycle → `count` = 2, `error` = 0.
  - At `count` = 0, `dec` alone → `count` = 0, `error` = 1, and `error` stays 1 until `reset`.
  - At `count` = 3, `inc` alone → `count` = 3, `error` = 1.
- **Reset mid-operation:** `reset` at edge 3 of OPEN with `count` = 2 → `gate_open` = 0 and `count` = 0 at the next edge, no `timeout` pulse, and a new `req` afterwards opens the gate normally.
